// File: rtl/axis_stream_sink.sv
// ---------------------------------------------------------------------------
// axis_stream_sink
//
// AXI-Stream slave endpoint. It drives a programmable tready backpressure
// pattern, checks every packet against an incrementing data pattern
// (beat n of a packet must carry n mod 2**DATA_WIDTH) and reports a
// per-packet summary plus running totals. It also watches the master for
// AXI-Stream stability violations.
//
// Handshake: a beat transfers at a posedge where axis_tvalid && axis_tready.
// Once the master raises axis_tvalid it must hold it, and keep tdata, tlast
// and tuser stable, until that transfer happens; axis_tready is registered
// and may drop without regard to axis_tvalid.
//
// Ports
//   aclk, areset   clock, synchronous active-high reset
//   axis_tdata     stream data                        (in,  DATA_WIDTH)
//   axis_tvalid    master beat valid                  (in)
//   axis_tready    sink ready, registered             (out)
//   axis_tlast     last beat of packet                (in)
//   axis_tuser     side-band, nonzero marks beat bad  (in,  USER_WIDTH)
//   sink_en        0 holds tready low                 (in)
//   stall_cycles   tready-low cycles after each beat  (in,  STALL_W)
//   pkt_done       1-cycle pulse, packet completed    (out)
//   pkt_len        beats in last packet, saturating   (out, LEN_W)
//   pkt_err        last packet was bad                (out)
//   pkt_count      packets completed, wrapping        (out, 16)
//   err_count      bad packets completed, saturating  (out, 16)
//   proto_err      sticky stability violation         (out)
//   dbg_state      FSM state (0 = RDY, 1 = STALL)      (out)
// ---------------------------------------------------------------------------
module axis_stream_sink #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int MAX_PKT_LEN = 256,
    parameter int STALL_W     = 4,
    localparam int LEN_W      = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_WIDTH-1:0] axis_tdata,
    input  logic                  axis_tvalid,
    output logic                  axis_tready,
    input  logic                  axis_tlast,
    input  logic [USER_WIDTH-1:0] axis_tuser,
    input  logic                  sink_en,
    input  logic [STALL_W-1:0]    stall_cycles,
    output logic                  pkt_done,
    output logic [LEN_W-1:0]      pkt_len,
    output logic                  pkt_err,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count,
    output logic                  proto_err,
    output logic                  dbg_state
);

    localparam logic RDY   = 1'b0;
    localparam logic STALL = 1'b1;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_LEN);

    logic                  state_q, state_d;
    logic [STALL_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                  tready_q, tready_d;
    logic [LEN_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic                  pkt_done_q, pkt_done_d;
    logic [LEN_W-1:0]      pkt_len_q, pkt_len_d;
    logic                  pkt_err_q, pkt_err_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [15:0]           err_count_q, err_count_d;
    logic                  proto_err_q, proto_err_d;

    // Snapshot of a beat that was offered but not taken, used to check that
    // the master holds it unchanged on the following cycle.
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] pend_data_q;
    logic                  pend_last_q;
    logic [USER_WIDTH-1:0] pend_user_q;

    logic                  accept;
    logic                  beat_bad;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  violation;

    always_comb begin
        accept   = axis_tvalid && tready_q;
        exp_data = DATA_WIDTH'(beat_cnt_q);
        // A beat arriving while beat_cnt already sits at MAX_LEN is overlength.
        beat_bad = (axis_tdata != exp_data) || (|axis_tuser) || (beat_cnt_q == MAX_LEN);

        // Backpressure FSM
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            RDY: begin
                if (accept && (stall_cycles != '0)) begin
                    state_d     = STALL;
                    stall_cnt_d = stall_cycles;
                end
            end
            STALL: begin
                // Leaving at cnt==1 yields exactly stall_cycles low cycles.
                if (stall_cnt_q == STALL_W'(1)) begin
                    state_d     = RDY;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d = stall_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d     = RDY;
                stall_cnt_d = '0;
            end
        endcase
        tready_d = (state_d == RDY) && sink_en;

        // Packet checker
        beat_cnt_d  = beat_cnt_q;
        err_flag_d  = err_flag_q;
        pkt_done_d  = 1'b0;
        pkt_len_d   = pkt_len_q;
        pkt_err_d   = pkt_err_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;
        if (accept) begin
            if (axis_tlast) begin
                // Close the packet and start the next one on the same edge.
                pkt_done_d  = 1'b1;
                pkt_len_d   = (beat_cnt_q == MAX_LEN) ? MAX_LEN : beat_cnt_q + 1'b1;
                pkt_err_d   = err_flag_q || beat_bad;
                pkt_count_d = pkt_count_q + 16'd1;
                if ((err_flag_q || beat_bad) && (err_count_q != 16'hFFFF)) begin
                    err_count_d = err_count_q + 16'd1;
                end
                beat_cnt_d = '0;
                err_flag_d = 1'b0;
            end else begin
                if (beat_cnt_q != MAX_LEN) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                err_flag_d = err_flag_q || beat_bad;
            end
        end

        // Stability monitor
        violation = pend_q && (!axis_tvalid ||
                               (axis_tdata != pend_data_q) ||
                               (axis_tlast != pend_last_q) ||
                               (axis_tuser != pend_user_q));
        proto_err_d = proto_err_q || violation;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q     <= RDY;
            stall_cnt_q <= '0;
            tready_q    <= 1'b0;
            beat_cnt_q  <= '0;
            err_flag_q  <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_len_q   <= '0;
            pkt_err_q   <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
            proto_err_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            pend_last_q <= 1'b0;
            pend_user_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            tready_q    <= tready_d;
            beat_cnt_q  <= beat_cnt_d;
            err_flag_q  <= err_flag_d;
            pkt_done_q  <= pkt_done_d;
            pkt_len_q   <= pkt_len_d;
            pkt_err_q   <= pkt_err_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
            proto_err_q <= proto_err_d;
            pend_q      <= axis_tvalid && !tready_q;
            pend_data_q <= axis_tdata;
            pend_last_q <= axis_tlast;
            pend_user_q <= axis_tuser;
        end
    end

    assign axis_tready = tready_q;
    assign pkt_done    = pkt_done_q;
    assign pkt_len     = pkt_len_q;
    assign pkt_err     = pkt_err_q;
    assign pkt_count   = pkt_count_q;
    assign err_count   = err_count_q;
    assign proto_err   = proto_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_axis_stream_sink.sv
module tb_axis_stream_sink;

  localparam int DW      = 8;
  localparam int UW      = 1;
  localparam int MAXLEN  = 8;
  localparam int SW      = 4;
  localparam int LW      = $clog2(MAXLEN + 1);
  localparam int EXP_W   = LW + 1 + 16 + 16;

  // ---------------- clock / reset ----------------
  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] axis_tdata = '0;
  logic          axis_tvalid = 1'b0;
  logic          axis_tready;
  logic          axis_tlast = 1'b0;
  logic [UW-1:0] axis_tuser = '0;
  logic          sink_en = 1'b1;
  logic [SW-1:0] stall_cycles = '0;
  logic          pkt_done;
  logic [LW-1:0] pkt_len;
  logic          pkt_err;
  logic [15:0]   pkt_count;
  logic [15:0]   err_count;
  logic          proto_err;
  logic          dbg_state;

  always #5 aclk = ~aclk;

  axis_stream_sink #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .MAX_PKT_LEN(MAXLEN),
    .STALL_W    (SW)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .axis_tdata  (axis_tdata),
    .axis_tvalid (axis_tvalid),
    .axis_tready (axis_tready),
    .axis_tlast  (axis_tlast),
    .axis_tuser  (axis_tuser),
    .sink_en     (sink_en),
    .stall_cycles(stall_cycles),
    .pkt_done    (pkt_done),
    .pkt_len     (pkt_len),
    .pkt_err     (pkt_err),
    .pkt_count   (pkt_count),
    .err_count   (err_count),
    .proto_err   (proto_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: beats of the packet in flight, plus running totals.
  int          cur_data[$];
  int          cur_user[$];
  int          model_pkts = 0;
  int          model_errs = 0;
  int          last_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Whole-packet view: length is beats seen capped at MAXLEN; a packet is bad
  // if it is too long, any beat carries tuser, or beat i is not i mod 256.
  task automatic model_close_packet();
    int n;
    int len;
    logic bad;
    n   = cur_data.size();
    len = (n > MAXLEN) ? MAXLEN : n;
    bad = (n > MAXLEN);
    for (int i = 0; i < n; i++) begin
      if (i < MAXLEN && cur_data[i] != (i % 256)) bad = 1'b1;
      if (cur_user[i] != 0) bad = 1'b1;
    end
    model_pkts = (model_pkts + 1) % 65536;
    if (bad && model_errs != 65535) model_errs++;
    exp_q.push_back({LW'(len), bad, 16'(model_pkts), 16'(model_errs)});
    cur_data.delete();
    cur_user.delete();
  endtask

  task automatic model_reset();
    cur_data.delete();
    cur_user.delete();
    model_pkts = 0;
    model_errs = 0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1. Holds the beat until accepted; returns at posedge+1
  // after the accepting edge. When chk_wait is set, the number of tready-low
  // cycles seen must equal the stall programmed at the previous accept.
  task automatic send_beat(input int data, input int user, input logic last, input logic chk_wait);
    int waits;
    logic ok;
    waits = 0;
    ok = 1'b0;
    axis_tdata  = DW'(data);
    axis_tuser  = UW'(user);
    axis_tlast  = last;
    axis_tvalid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge aclk);
      if (axis_tready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      check("accept_timeout", 64'(0), 64'(1));
    end else begin
      if (chk_wait) check("stall_gap", 64'(waits), 64'(last_stall));
      last_stall = int'(stall_cycles);
      @(posedge aclk);
      #1;
      cur_data.push_back(data % 256);
      cur_user.push_back(user);
      if (last) model_close_packet();
    end
  endtask

  task automatic idle(input int n);
    axis_tvalid = 1'b0;
    axis_tlast  = 1'b0;
    axis_tuser  = '0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // n beats; beat bad_idx gets corrupted data, beat user_idx gets tuser=1.
  task automatic send_pkt(input int n, input int bad_idx, input int user_idx, input int stall);
    stall_cycles = SW'(stall);
    for (int i = 0; i < n; i++) begin
      send_beat((i == bad_idx) ? (i ^ 7) : i, (i == user_idx) ? 1 : 0, (i == n - 1), (i > 0));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge aclk) begin
    if (!areset && pkt_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pkt_done", 64'(1), 64'(0));
      end else begin
        logic [EXP_W-1:0] e;
        e = exp_q.pop_front();
        check("pkt_len",   64'(pkt_len),   64'(e[EXP_W-1 -: LW]));
        check("pkt_err",   64'(pkt_err),   64'(e[32]));
        check("pkt_count", 64'(pkt_count), 64'(e[31:16]));
        check("err_count", 64'(err_count), 64'(e[15:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset for 3 cycles
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_tready",  64'(axis_tready), 64'(0));
    check("rst_outputs", 64'({pkt_done, pkt_len, pkt_err, pkt_count, err_count, proto_err}), 64'(0));
    areset = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("tready_after_release", 64'(axis_tready), 64'(1));
    @(posedge aclk);
    #1;

    // Clean 4-beat packet, no stall
    send_pkt(4, -1, -1, 0);
    idle(3);
    // 3-beat packet with 2-cycle stalls
    send_pkt(3, -1, -1, 2);
    idle(4);
    // Data error (0,1,5,3) then a clean 0,1
    send_pkt(4, 2, -1, 0);
    send_pkt(2, -1, -1, 0);
    idle(3);
    // Overlength 10 beats, then tuser on beat 0
    send_pkt(10, -1, -1, 1);
    send_pkt(2, -1, 0, 0);
    idle(3);
    // Single-beat packets back to back
    send_pkt(1, -1, -1, 0);
    send_pkt(1, -1, -1, 0);
    idle(3);

    // Randomized packets
    for (int p = 0; p < 40; p++) begin
      int n;
      int bad;
      int usr;
      n   = $urandom_range(1, 10);
      bad = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      usr = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
      send_pkt(n, bad, usr, $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    stall_cycles = '0;
    idle(6);
    check("pending_empty_mid", 64'(exp_q.size()), 64'(0));

    // Protocol violation: tvalid dropped while tready is low
    @(negedge aclk);
    check("proto_clean", 64'(proto_err), 64'(0));
    @(posedge aclk);
    #1;
    sink_en = 1'b0;
    idle(2);
    axis_tdata  = 8'h33;
    axis_tvalid = 1'b1;
    @(posedge aclk);
    #1;
    axis_tvalid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    check("proto_set", 64'(proto_err), 64'(1));
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    check("proto_sticky", 64'(proto_err), 64'(1));
    check("backpressure_low", 64'(axis_tready), 64'(0));
    @(posedge aclk);
    #1;
    sink_en = 1'b1;
    idle(2);

    // Reset mid-packet after 2 beats
    send_beat(0, 0, 1'b0, 1'b0);
    send_beat(1, 0, 1'b0, 1'b0);
    axis_tvalid = 1'b0;
    areset = 1'b1;
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    @(negedge aclk);
    check("proto_cleared", 64'(proto_err), 64'(0));
    check("count_cleared", 64'(pkt_count), 64'(0));
    @(posedge aclk);
    #1;
    send_pkt(3, -1, -1, 0);
    idle(4);
    check("pending_empty_end", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
